// File: rtl/hram_word_packer.sv
// Packs RATIO consecutive FIFO words into one wide beat for the HRAM write path.
// A partial beat goes out with a lane-keep mask on idle timeout or on a flush request.
module hram_word_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   out_clk,
    input  logic                   reset,
    input  logic                   fifo_e,
    input  logic [WIDTH-1:0]       fifo_dout,
    output logic                   fifo_rd,
    input  logic                   flush,
    output logic [WIDTH*RATIO-1:0] pkt_data,
    output logic [RATIO-1:0]       pkt_keep,
    output logic                   pkt_valid,
    input  logic                   pkt_ready
);

    localparam int FW = $clog2(RATIO + 1);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(RATIO);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                   state, state_nxt;
    logic [FW-1:0]            fill_cnt, fill_nxt;
    logic                     rd_pend;
    logic [IW-1:0]            idle_cnt, idle_nxt;
    logic                     flush_req, flush_nxt;
    logic [WIDTH*RATIO-1:0]   data_q, data_nxt;
    logic [RATIO-1:0]         keep_q, keep_nxt;
    logic                     valid_q, valid_nxt;
    logic [FW:0]              occupancy;
    logic                     full, timed_out, flushed;

    // Words already captured plus the one still in flight must leave room in the beat.
    assign occupancy = {1'b0, fill_cnt} + {{FW{1'b0}}, rd_pend};

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        idle_nxt  = idle_cnt;
        flush_nxt = flush_req;
        data_nxt  = data_q;
        keep_nxt  = keep_q;
        valid_nxt = valid_q;
        full      = 1'b0;
        timed_out = 1'b0;
        flushed   = 1'b0;
        fifo_rd   = !reset && (state == FILL) && !fifo_e &&
                    (occupancy < {1'b0, FILL_MAX}) && !flush_req;

        case (state)
            FILL: begin
                for (int k = 0; k < RATIO; k++) begin
                    if (rd_pend && (fill_cnt == FW'(k))) begin
                        data_nxt[k*WIDTH +: WIDTH] = fifo_dout;
                        keep_nxt[k]                = 1'b1;
                    end
                end
                if (rd_pend) begin
                    fill_nxt = fill_cnt + FW'(1);
                end

                if (rd_pend || !fifo_e) begin
                    idle_nxt = '0;
                end else if ((fill_cnt != '0) && (idle_cnt != IDLE_MAX)) begin
                    idle_nxt = idle_cnt + IW'(1);
                end

                // A flush with nothing captured and nothing in flight is simply dropped.
                if (flush) begin
                    flush_nxt = 1'b1;
                end else if (flush_req && !rd_pend && (fill_cnt == '0)) begin
                    flush_nxt = 1'b0;
                end

                full      = (fill_nxt == FILL_MAX);
                timed_out = (TIMEOUT > 0) && (idle_nxt == IDLE_MAX) && (fill_nxt != '0);
                flushed   = flush_req && !rd_pend && (fill_nxt != '0);

                if (full || timed_out || flushed) begin
                    state_nxt = HOLD;
                    valid_nxt = 1'b1;
                    idle_nxt  = '0;
                    flush_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (pkt_ready) begin
                    state_nxt = FILL;
                    valid_nxt = 1'b0;
                    fill_nxt  = '0;
                    keep_nxt  = '0;
                    data_nxt  = '0;
                    flush_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge out_clk) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            rd_pend   <= 1'b0;
            idle_cnt  <= '0;
            flush_req <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            rd_pend   <= fifo_rd;
            idle_cnt  <= idle_nxt;
            flush_req <= flush_nxt;
            data_q    <= data_nxt;
            keep_q    <= keep_nxt;
            valid_q   <= valid_nxt;
        end
    end

    assign pkt_data  = data_q;
    assign pkt_keep  = keep_q;
    assign pkt_valid = valid_q;

endmodule

// File: tb/tb_hram_word_packer.sv
// Directed and randomized checks of hram_word_packer against FIFO queue models
// and a word-grouping reference (consecutive words grouped RATIO at a time).
module tb_hram_word_packer;

    localparam int W = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset  = 1'b1;
    logic flush0 = 1'b0;
    logic ready0 = 1'b0;
    logic flush_t = 1'b0;
    logic ready4 = 1'b1;
    logic ready2 = 1'b1;

    logic         rd0, rd4, rd2;
    logic         fe0 = 1'b1, fe4 = 1'b1, fe2 = 1'b1;
    logic [W-1:0] do0 = '0, do4 = '0, do2 = '0;
    logic [31:0]  d0, d4, d2;
    logic [3:0]   k0, k4, k2;
    logic         v0, v4, v2;

    hram_word_packer #(.WIDTH(W), .RATIO(R), .TIMEOUT(16)) u_dut (
        .out_clk(clk), .reset(reset), .fifo_e(fe0), .fifo_dout(do0), .fifo_rd(rd0),
        .flush(flush0), .pkt_data(d0), .pkt_keep(k0), .pkt_valid(v0), .pkt_ready(ready0)
    );
    hram_word_packer #(.WIDTH(W), .RATIO(R), .TIMEOUT(4)) u_t4 (
        .out_clk(clk), .reset(reset), .fifo_e(fe4), .fifo_dout(do4), .fifo_rd(rd4),
        .flush(flush_t), .pkt_data(d4), .pkt_keep(k4), .pkt_valid(v4), .pkt_ready(ready4)
    );
    hram_word_packer #(.WIDTH(W), .RATIO(R), .TIMEOUT(2)) u_t2 (
        .out_clk(clk), .reset(reset), .fifo_e(fe2), .fifo_dout(do2), .fifo_rd(rd2),
        .flush(flush_t), .pkt_data(d2), .pkt_keep(k2), .pkt_valid(v2), .pkt_ready(ready2)
    );

    // FIFO read-side models: registered data_out, empty flag tracks the queue after each edge.
    logic [W-1:0] q0[$], q4[$], q2[$];
    always @(posedge clk) begin
        if (rd0 && q0.size() != 0) do0 <= q0.pop_front();
        fe0 <= (q0.size() == 0);
        if (rd4 && q4.size() != 0) do4 <= q4.pop_front();
        fe4 <= (q4.size() == 0);
        if (rd2 && q2.size() != 0) do2 <= q2.pop_front();
        fe2 <= (q2.size() == 0);
    end

    // Accepted beats, sampled between the input drive point and the next active edge.
    logic [31:0] got_d0[$], got_d4[$], got_d2[$];
    logic [3:0]  got_k0[$], got_k4[$], got_k2[$];
    always @(negedge clk) begin
        #2;
        if (v0 && ready0) begin got_d0.push_back(d0); got_k0.push_back(k0); end
        if (v4 && ready4) begin got_d4.push_back(d4); got_k4.push_back(k4); end
        if (v2 && ready2) begin got_d2.push_back(d2); got_k2.push_back(k2); end
    end

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run0(input int n, output int rds, output int vals,
                        output int first_rd, output int last_rd, output int first_val);
        rds = 0; vals = 0; first_rd = -1; last_rd = -1; first_val = -1;
        for (int i = 0; i < n; i++) begin
            if (rd0) begin
                rds++;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (v0) begin
                vals++;
                if (first_val < 0) first_val = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rd0(input string tag);
        int i = 0;
        while (!rd0 && i < 10) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(rd0), 32'd1);
    endtask

    function automatic logic [31:0] beat_idx_d(input int i);
        return (i < got_d0.size()) ? got_d0[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [3:0] beat_idx_k(input int i);
        return (i < got_k0.size()) ? got_k0[i] : 4'hx;
    endfunction

    initial begin
        int rds, vals, frd, lrd, fval;
        logic [W-1:0] w[4];
        logic [W-1:0] rw;
        logic [31:0] ed;
        logic [3:0]  ek;
        int n_words, base, nb, gap;

        // Reset with words waiting: no pops, all outputs cleared.
        reset = 1'b1;
        q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h33); q0.push_back(8'h44);
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_data", d0, 32'd0);
        chk("rst_keep", 32'(k0), 32'd0);
        chk("rst_fifo_rd", 32'(rd0), 32'd0);

        // Full beat with ready high.
        reset = 1'b0;
        ready0 = 1'b1;
        #1;
        run0(12, rds, vals, frd, lrd, fval);
        chk("t1_pops", rds, 4);
        chk("t1_pops_consecutive", lrd - frd, 3);
        chk("t1_valid_cycles", vals, 1);
        chk("t1_beat_count", got_d0.size(), 1);
        chk("t1_data", beat_idx_d(0), 32'h44332211);
        chk("t1_keep", 32'(beat_idx_k(0)), 32'hf);

        // Full beat held under backpressure while the FIFO still has data.
        ready0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            q0.push_back(w[i]);
        end
        repeat (8) @(negedge clk);
        q0.push_back(8'hA1);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", 32'(v0), 32'd1);
            chk("t2_hold_data", d0, {w[3], w[2], w[1], w[0]});
            chk("t2_hold_no_pop", 32'(rd0), 32'd0);
            @(negedge clk);
        end
        ready0 = 1'b1;
        @(negedge clk);
        chk("t2_valid_drop", 32'(v0), 32'd0);
        chk("t2_data", beat_idx_d(1), {w[3], w[2], w[1], w[0]});

        // Two words then an empty FIFO: pop, capture, 16 idle cycles, then valid.
        q0.push_back(8'hB2);
        run0(30, rds, vals, frd, lrd, fval);
        chk("t3_pops", rds, 2);
        chk("t3_timeout_latency", fval - lrd, 18);
        chk("t3_valid_cycles", vals, 1);
        chk("t3_data", beat_idx_d(2), 32'h0000B2A1);
        chk("t3_keep", 32'(beat_idx_k(2)), 32'h3);

        // Flush raised while the third pop is issued: the fourth pop is held back.
        q0.push_back(8'hC1); q0.push_back(8'hC2); q0.push_back(8'hC3); q0.push_back(8'hC4);
        wait_rd0("t4_first_pop");
        @(negedge clk);
        @(negedge clk);
        chk("t4_third_pop", 32'(rd0), 32'd1);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        chk("t4_fourth_pop_blocked", 32'(rd0), 32'd0);
        run0(10, rds, vals, frd, lrd, fval);
        chk("t4_valid_cycles", vals, 1);
        chk("t4_data", beat_idx_d(3), 32'h00C3C2C1);
        chk("t4_keep", 32'(beat_idx_k(3)), 32'h7);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        run0(6, rds, vals, frd, lrd, fval);
        chk("t4_single_word_valid", vals, 1);
        chk("t4_single_word_data", beat_idx_d(4), 32'h000000C4);
        chk("t4_single_word_keep", 32'(beat_idx_k(4)), 32'h1);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        run0(30, rds, vals, frd, lrd, fval);
        chk("t4_empty_flush_no_beat", vals, 0);
        chk("t4_beat_count", got_d0.size(), 5);

        // Reset with two words captured and one in flight.
        q0.push_back(8'hD1); q0.push_back(8'hD2); q0.push_back(8'hD3);
        wait_rd0("t5_first_pop");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", 32'(v0), 32'd0);
        chk("t5_rst_data", d0, 32'd0);
        chk("t5_rst_keep", 32'(k0), 32'd0);
        chk("t5_rst_fifo_rd", 32'(rd0), 32'd0);
        reset = 1'b0;
        q0.push_back(8'hE1); q0.push_back(8'hE2); q0.push_back(8'hE3); q0.push_back(8'hE4);
        run0(12, rds, vals, frd, lrd, fval);
        chk("t5_beat_count", got_d0.size(), 6);
        chk("t5_data", beat_idx_d(5), 32'hE4E3E2E1);
        chk("t5_keep", 32'(beat_idx_k(5)), 32'hf);

        // Random words, random gaps well under the timeout, random backpressure.
        base = got_d0.size();
        n_words = $urandom_range(41, 62);
        nb = (n_words + R - 1) / R;
        for (int i = 0; i < n_words; i++) begin
            rw = 8'($urandom);
            q0.push_back(rw);
            exp_q.push_back(rw);
            gap = $urandom_range(1, 6);
            for (int g = 0; g < gap; g++) begin
                ready0 = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
        end
        ready0 = 1'b1;
        for (int i = 0; i < 400 && got_d0.size() < base + nb; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rnd_beat_count", got_d0.size() - base, nb);
        for (int b = 0; b < nb; b++) begin
            ed = '0;
            ek = '0;
            for (int k = 0; k < R && exp_q.size() > 0; k++) begin
                ed[k*W +: W] = exp_q.pop_front();
                ek[k] = 1'b1;
            end
            chk("rnd_data", beat_idx_d(base + b), ed);
            chk("rnd_keep", 32'(beat_idx_k(base + b)), 32'(ek));
        end

        // One word every 4 cycles: two idle cycles between captures.
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            q4.push_back(w[i]);
            q2.push_back(w[i]);
            repeat (4) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("t6_t4_beat_count", got_d4.size(), 1);
        chk("t6_t4_data", (got_d4.size() > 0) ? got_d4[0] : 32'hDEAD_BEEF, {w[3], w[2], w[1], w[0]});
        chk("t6_t4_keep", (got_k4.size() > 0) ? 32'(got_k4[0]) : 32'hx, 32'hf);
        chk("t6_t2_data", (got_d2.size() > 0) ? got_d2[0] : 32'hDEAD_BEEF, {24'h0, w[0]});
        chk("t6_t2_keep", (got_k2.size() > 0) ? 32'(got_k2[0]) : 32'hx, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
